// File: rtl/dcache_flush_walker.sv
// rtl/dcache_flush_walker.sv - dcache flush responder: walks all sets/ways, writes back dirty lines, invalidates, acks.
// Optional write-back perf counter enabled by DCACHE_FLUSH_PERF_CNT_EN.
module dcache_flush_walker #(
    parameter int NUM_SETS = 256,
    parameter int NUM_WAYS = 8,
    parameter int TAG_W    = 44,
    parameter int OFFSET_W = 4,
    parameter int ADDR_W   = 56,
    localparam int IDX_W   = $clog2(NUM_SETS),
    localparam int WAY_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    output logic              flush_ack_o,
    output logic              busy_o,
    output logic              tag_req_o,
    output logic [IDX_W-1:0]  tag_set_o,
    output logic [WAY_W-1:0]  tag_way_o,
    input  logic              tag_valid_i,
    input  logic              tag_dirty_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              wb_req_o,
    output logic [ADDR_W-1:0] wb_addr_o,
    input  logic              wb_gnt_i,
    output logic              inv_we_o
`ifdef DCACHE_FLUSH_PERF_CNT_EN
    ,
    output logic [31:0]       wb_count_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CHECK = 3'd2,
        S_WB    = 3'd3,
        S_INV   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   set_q;
    logic [WAY_W-1:0]   way_q;
    logic [ADDR_W-1:0]  wb_addr_q;
    logic               way_last;
    logic               line_last;

    assign way_last  = (way_q == WAY_W'(NUM_WAYS - 1));
    assign line_last = way_last && (set_q == IDX_W'(NUM_SETS - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (flush_i) state_d = S_READ;
            S_READ:  state_d = S_CHECK;
            S_CHECK: state_d = (tag_valid_i && tag_dirty_i) ? S_WB : S_INV;
            S_WB:    if (wb_gnt_i) state_d = S_INV;
            S_INV:   state_d = line_last ? S_DONE : S_READ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Way is the inner loop so consecutive reads stay within one set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            set_q     <= '0;
            way_q     <= '0;
            wb_addr_q <= '0;
        end else begin
            if (state_q == S_IDLE && flush_i) begin
                set_q <= '0;
                way_q <= '0;
            end else if (state_q == S_INV && !line_last) begin
                if (way_last) begin
                    way_q <= '0;
                    set_q <= set_q + 1'b1;
                end else begin
                    way_q <= way_q + 1'b1;
                end
            end
            if (state_q == S_CHECK && tag_valid_i && tag_dirty_i) begin
                wb_addr_q <= {tag_i, set_q, {OFFSET_W{1'b0}}};
            end
        end
    end

`ifdef DCACHE_FLUSH_PERF_CNT_EN
    logic [31:0] wb_count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_count_q <= '0;
        end else if (state_q == S_IDLE && flush_i) begin
            wb_count_q <= '0;
        end else if (state_q == S_WB && wb_gnt_i && wb_count_q != '1) begin
            wb_count_q <= wb_count_q + 32'd1;
        end
    end

    assign wb_count_o = wb_count_q;
`endif

    // Every output is a decode of registered state; no input reaches an output combinationally.
    always_comb begin
        tag_req_o   = (state_q == S_READ);
        wb_req_o    = (state_q == S_WB);
        inv_we_o    = (state_q == S_INV);
        flush_ack_o = (state_q == S_DONE);
        busy_o      = (state_q != S_IDLE);
        tag_set_o   = set_q;
        tag_way_o   = way_q;
        wb_addr_o   = wb_addr_q;
    end

endmodule

// File: tb/tb_dcache_flush_walker.sv
// tb/tb_dcache_flush_walker.sv - directed self-checking bench for dcache_flush_walker (4 sets x 2 ways).
module tb_dcache_flush_walker;

    localparam int NUM_SETS = 4;
    localparam int NUM_WAYS = 2;
    localparam int TAG_W    = 8;
    localparam int OFFSET_W = 4;
    localparam int ADDR_W   = 14;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush_i;
    logic              flush_ack_o;
    logic              busy_o;
    logic              tag_req_o;
    logic [1:0]        tag_set_o;
    logic [0:0]        tag_way_o;
    logic              tag_valid_i;
    logic              tag_dirty_i;
    logic [TAG_W-1:0]  tag_i;
    logic              wb_req_o;
    logic [ADDR_W-1:0] wb_addr_o;
    logic              wb_gnt_i;
    logic              inv_we_o;
`ifdef DCACHE_FLUSH_PERF_CNT_EN
    logic [31:0]       wb_count_o;
`endif

    always #5 clk = ~clk;

    dcache_flush_walker #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS),
        .TAG_W    (TAG_W),
        .OFFSET_W (OFFSET_W),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush_i),
        .flush_ack_o (flush_ack_o),
        .busy_o      (busy_o),
        .tag_req_o   (tag_req_o),
        .tag_set_o   (tag_set_o),
        .tag_way_o   (tag_way_o),
        .tag_valid_i (tag_valid_i),
        .tag_dirty_i (tag_dirty_i),
        .tag_i       (tag_i),
        .wb_req_o    (wb_req_o),
        .wb_addr_o   (wb_addr_o),
        .wb_gnt_i    (wb_gnt_i),
        .inv_we_o    (inv_we_o)
`ifdef DCACHE_FLUSH_PERF_CNT_EN
        ,
        .wb_count_o  (wb_count_o)
`endif
    );

    // Tag SRAM model: one-cycle read latency, cleared by invalidate.
    logic             mv [NUM_SETS][NUM_WAYS];
    logic             md [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0] mt [NUM_SETS][NUM_WAYS];

    always @(posedge clk) begin
        tag_valid_i <= tag_req_o ? mv[tag_set_o][tag_way_o] : 1'b0;
        tag_dirty_i <= tag_req_o ? md[tag_set_o][tag_way_o] : 1'b0;
        tag_i       <= tag_req_o ? mt[tag_set_o][tag_way_o] : '0;
        if (inv_we_o) begin
            mv[tag_set_o][tag_way_o] <= 1'b0;
            md[tag_set_o][tag_way_o] <= 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;

    int cyc, ack_cyc, inv_n, wb_cyc, inv_bad, unstable, excl_bad, busy_bad;
    int inv21_cyc, last_wb_cyc, n_ack, n_strobe;
    logic [ADDR_W-1:0] wb_addr_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_lines();
        for (int s = 0; s < NUM_SETS; s++) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                mv[s][w] = 1'b0;
                md[s][w] = 1'b0;
                mt[s][w] = '0;
            end
        end
    endtask

    task automatic set_line(input int s, input int w, input logic v, input logic d, input logic [TAG_W-1:0] t);
        mv[s][w] = v;
        md[s][w] = d;
        mt[s][w] = t;
    endtask

    // Cycle 0 is the IDLE cycle in which flush_i is first seen high.
    task automatic run_walk(input int drop_at, input int stall);
        int  j;
        int  strobes;
        logic done;
        ack_cyc = -1; inv_n = 0; wb_cyc = 0; inv_bad = 0; unstable = 0;
        excl_bad = 0; busy_bad = 0; inv21_cyc = -1; last_wb_cyc = -1;
        wb_addr_seen = '0;
        j = 0;
        done = 1'b0;
        @(negedge clk);
        flush_i = 1'b1;
        cyc = 0;
        if (busy_o !== 1'b0) busy_bad++;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (cyc == drop_at) flush_i = 1'b0;
            strobes = int'(tag_req_o) + int'(wb_req_o) + int'(inv_we_o) + int'(flush_ack_o);
            if (strobes > 1) excl_bad++;
            if (busy_o !== 1'b1) busy_bad++;
            wb_gnt_i = 1'b0;
            if (wb_req_o) begin
                j++;
                wb_cyc++;
                if (j == 1) wb_addr_seen = wb_addr_o;
                else if (wb_addr_o !== wb_addr_seen) unstable++;
                if (j > stall) begin
                    wb_gnt_i = 1'b1;
                    last_wb_cyc = cyc;
                end
            end else begin
                j = 0;
            end
            if (inv_we_o) begin
                if (tag_set_o !== 2'(inv_n / NUM_WAYS) || tag_way_o !== 1'(inv_n % NUM_WAYS)) inv_bad++;
                if (tag_set_o == 2'd2 && tag_way_o == 1'b1) inv21_cyc = cyc;
                inv_n++;
            end
            if (flush_ack_o) begin
                ack_cyc = cyc;
                done = 1'b1;
                flush_i = 1'b0;
            end
        end
        flush_i = 1'b0;
        wb_gnt_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        flush_i = 1'b0;
        wb_gnt_i = 1'b0;
        clear_lines();
        repeat (2) @(negedge clk);
        chk("reset_outputs", {flush_ack_o, busy_o, tag_req_o, wb_req_o, inv_we_o, tag_set_o, tag_way_o, wb_addr_o}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", {flush_ack_o, busy_o, tag_req_o, wb_req_o, inv_we_o, tag_set_o, tag_way_o, wb_addr_o}, '0);

        // All lines invalid
        run_walk(1000, 0);
        chk("inv_ack_cycle", ack_cyc, 25);
        chk("inv_pulses", inv_n, 8);
        chk("inv_order", inv_bad, 0);
        chk("inv_no_wb", wb_cyc, 0);
        chk("inv_exclusive", excl_bad, 0);
        chk("inv_busy", busy_bad, 0);
        repeat (3) @(negedge clk);

        // One dirty line at (2,1), immediate grant
        clear_lines();
        set_line(2, 1, 1'b1, 1'b1, 8'hA5);
        run_walk(1000, 0);
        chk("dirty_ack_cycle", ack_cyc, 26);
        chk("dirty_wb_cycles", wb_cyc, 1);
        chk("dirty_wb_addr", wb_addr_seen, 14'h2960);
        chk("dirty_inv_pulses", inv_n, 8);
        chk("dirty_inv_order", inv_bad, 0);
        chk("dirty_exclusive", excl_bad, 0);
`ifdef DCACHE_FLUSH_PERF_CNT_EN
        chk("dirty_wb_count", wb_count_o, 1);
`endif
        repeat (3) @(negedge clk);

        // Grant stalled five cycles
        clear_lines();
        set_line(2, 1, 1'b1, 1'b1, 8'hA5);
        run_walk(1000, 5);
        chk("stall_ack_cycle", ack_cyc, 31);
        chk("stall_wb_cycles", wb_cyc, 6);
        chk("stall_addr_stable", unstable, 0);
        chk("stall_wb_addr", wb_addr_seen, 14'h2960);
        chk("stall_grant_cycle", last_wb_cyc, 23);
        chk("stall_inv_after_grant", inv21_cyc, 24);
        chk("stall_busy", busy_bad, 0);
`ifdef DCACHE_FLUSH_PERF_CNT_EN
        chk("stall_wb_count", wb_count_o, 1);
`endif
        repeat (3) @(negedge clk);

        // Valid clean line and invalid dirty line never write back
        clear_lines();
        set_line(0, 0, 1'b1, 1'b0, 8'h3C);
        set_line(1, 0, 1'b0, 1'b1, 8'h77);
        run_walk(1000, 0);
        chk("clean_ack_cycle", ack_cyc, 25);
        chk("clean_no_wb", wb_cyc, 0);
        chk("clean_inv_pulses", inv_n, 8);
        repeat (3) @(negedge clk);

        // Reset during a write-back stall
        clear_lines();
        set_line(2, 1, 1'b1, 1'b1, 8'hA5);
        @(negedge clk);
        flush_i = 1'b1;
        wb_gnt_i = 1'b0;
        repeat (20) @(negedge clk);
        flush_i = 1'b0;
        chk("rst_in_wb", wb_req_o, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_outputs_zero", {flush_ack_o, busy_o, tag_req_o, wb_req_o, inv_we_o, tag_set_o, tag_way_o, wb_addr_o}, '0);
`ifdef DCACHE_FLUSH_PERF_CNT_EN
        chk("rst_wb_count", wb_count_o, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        n_ack = 0;
        n_strobe = 0;
        repeat (30) begin
            @(negedge clk);
            if (flush_ack_o) n_ack++;
            if (tag_req_o || wb_req_o || inv_we_o || busy_o) n_strobe++;
        end
        chk("rst_no_ack", n_ack, 0);
        chk("rst_no_strobes", n_strobe, 0);
        run_walk(1000, 0);
        chk("reflush_ack_cycle", ack_cyc, 26);
        chk("reflush_inv_order", inv_bad, 0);
        chk("reflush_inv_pulses", inv_n, 8);
        repeat (3) @(negedge clk);

        // Early drop, then back-to-back request in the IDLE cycle after DONE
        clear_lines();
        run_walk(3, 0);
        chk("drop_ack_cycle", ack_cyc, 25);
        chk("drop_busy", busy_bad, 0);
        run_walk(1000, 0);
        chk("b2b_ack_cycle", ack_cyc, 25);
        chk("b2b_inv_pulses", inv_n, 8);
        chk("b2b_busy", busy_bad, 0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
